// File: rtl/fc1_intstat_ctr.sv
// ============================================================================
// fc1_intstat_ctr
// ----------------------------------------------------------------------------
// Interval-statistics engine for the FC1 layer. It accumulates NUM_CH
// independent per-lane event streams into per-channel counters. Each counter
// either saturates at all-ones or wraps modulo 2^CNT_W, as SAT selects. On
// every interval tick the engine copies all counters into a stable snapshot
// bank for register readout, then restarts accumulation from zero.
//
// Parameters
//   NUM_CH : number of event channels
//   CNT_W  : accumulator / snapshot width per channel (8..48)
//   INC_W  : per-channel increment width per cycle
//   SAT    : 1 = saturate at all-ones, 0 = wrap modulo 2^CNT_W
//
// Ports
//   clk       : single clock domain
//   rst_n     : synchronous active-low reset
//   stats_en  : 1 = accumulate increments; ticks are honoured either way
//   inc       : per-channel increment, channel c at [c*INC_W +: INC_W]
//   iv_tick   : single-cycle interval boundary strobe
//   sw_clr    : single-cycle clear of running accumulators and overflow flags
//   snap_cnt  : snapshot bank, channel c at [c*CNT_W +: CNT_W]
//   snap_ovf  : per-channel overflow seen during the snapshotted interval
//   snap_vld  : one-cycle pulse when the snapshot bank updates
//   snap_seq  : snapshot sequence number, wraps 255 -> 0
// ============================================================================
module fc1_intstat_ctr #(
    parameter int NUM_CH = 5,
    parameter int CNT_W  = 32,
    parameter int INC_W  = 1,
    parameter bit SAT    = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stats_en,
    input  logic [NUM_CH*INC_W-1:0]   inc,
    input  logic                      iv_tick,
    input  logic                      sw_clr,
    output logic [NUM_CH*CNT_W-1:0]   snap_cnt,
    output logic [NUM_CH-1:0]         snap_ovf,
    output logic                      snap_vld,
    output logic [7:0]                snap_seq
);

    // Running accumulators. Element c of the packed array lines up with
    // channel c of the flat snapshot bus, so a snapshot is a direct copy.
    logic [NUM_CH-1:0][CNT_W-1:0] acc;
    logic [NUM_CH-1:0][CNT_W-1:0] acc_next;
    logic [NUM_CH-1:0]            ovf;
    logic [NUM_CH-1:0]            ovf_now;

    // One extra bit of headroom. The carry out of the top bit is the
    // overflow event. This also covers "already all-ones and inc > 0".
    logic [CNT_W:0] inc_ext;
    logic [CNT_W:0] sum;

    always_comb begin
        // NOTE: give every always_comb target a value before any branch;
        // a path that leaves one unassigned infers a latch.
        acc_next = acc;
        ovf_now  = '0;
        inc_ext  = '0;
        sum      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            inc_ext = '0;
            if (stats_en) begin
                inc_ext[INC_W-1:0] = inc[c*INC_W +: INC_W];
            end
            sum        = {1'b0, acc[c]} + inc_ext;
            ovf_now[c] = sum[CNT_W];
            if (sum[CNT_W] && SAT) begin
                acc_next[c] = '1;
            end else begin
                acc_next[c] = sum[CNT_W-1:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the accumulators are ordinary flops rather than a RAM,
            // so they are reset together with the rest of the state; a
            // mid-interval reset must drop the partial counts.
            acc      <= '0;
            ovf      <= '0;
            snap_cnt <= '0;
            snap_ovf <= '0;
            snap_vld <= 1'b0;
            snap_seq <= 8'd0;
        end else begin
            snap_vld <= iv_tick;
            if (iv_tick) begin
                // The tick cycle's increment belongs to the closing interval.
                // A coincident sw_clr changes nothing, because the counters
                // restart anyway.
                snap_cnt <= acc_next;
                snap_ovf <= ovf | ovf_now;
                snap_seq <= snap_seq + 8'd1;
                acc      <= '0;
                ovf      <= '0;
            end else if (sw_clr) begin
                // The increment arriving with a clear is discarded.
                acc <= '0;
                ovf <= '0;
            end else begin
                acc <= acc_next;
                ovf <= ovf | ovf_now;
            end
        end
    end

endmodule

// File: tb/tb_fc1_intstat_ctr.sv
// ============================================================================
// tb_fc1_intstat_ctr
// ----------------------------------------------------------------------------
// Three instances share the control inputs:
//   u_a : defaults (5 ch, 32-bit counters, 1-bit increments, saturating)
//   u_b : 5 ch, 8-bit counters, 4-bit increments, saturating
//   u_c : 5 ch, 8-bit counters, 4-bit increments, wrapping
// The reference model keeps the true arithmetic total of each channel's
// interval. A snapshot is min(total, max) when saturating and total mod 2^W
// when wrapping. The overflow flag is simply total > max.
// ============================================================================
module tb_fc1_intstat_ctr;

    localparam int NCH = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         stats_en;
    logic         iv_tick;
    logic         sw_clr;
    logic [4:0]   inc_a;
    logic [19:0]  inc_b;

    logic [159:0] a_cnt;
    logic [39:0]  b_cnt, c_cnt;
    logic [4:0]   a_ovf, b_ovf, c_ovf;
    logic         a_vld, b_vld, c_vld;
    logic [7:0]   a_seq, b_seq, c_seq;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: [instance][channel]
    longint tot  [3][NCH];
    longint ecnt [3][NCH];
    bit     eovf [3][NCH];
    bit     evld;
    int     eseq;

    always #5 clk = ~clk;

    fc1_intstat_ctr u_a (
        .clk(clk), .rst_n(rst_n), .stats_en(stats_en), .inc(inc_a),
        .iv_tick(iv_tick), .sw_clr(sw_clr),
        .snap_cnt(a_cnt), .snap_ovf(a_ovf), .snap_vld(a_vld), .snap_seq(a_seq)
    );

    fc1_intstat_ctr #(.NUM_CH(5), .CNT_W(8), .INC_W(4), .SAT(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .stats_en(stats_en), .inc(inc_b),
        .iv_tick(iv_tick), .sw_clr(sw_clr),
        .snap_cnt(b_cnt), .snap_ovf(b_ovf), .snap_vld(b_vld), .snap_seq(b_seq)
    );

    fc1_intstat_ctr #(.NUM_CH(5), .CNT_W(8), .INC_W(4), .SAT(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .stats_en(stats_en), .inc(inc_b),
        .iv_tick(iv_tick), .sw_clr(sw_clr),
        .snap_cnt(c_cnt), .snap_ovf(c_ovf), .snap_vld(c_vld), .snap_seq(c_seq)
    );

    task automatic check(input string tag, input logic [159:0] obs,
                         input logic [159:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint max_of(input int k);
        return (k == 0) ? 64'hFFFF_FFFF : 64'd255;
    endfunction

    function automatic longint inc_of(input int k, input int c);
        return (k == 0) ? longint'(inc_a[c]) : longint'(inc_b[c*4 +: 4]);
    endfunction

    // Apply the rules for one clock edge, using the inputs present at it.
    task automatic model_edge();
        longint t;
        if (!rst_n) begin
            for (int k = 0; k < 3; k++)
                for (int c = 0; c < NCH; c++) begin
                    tot[k][c] = 0; ecnt[k][c] = 0; eovf[k][c] = 1'b0;
                end
            evld = 1'b0;
            eseq = 0;
        end else begin
            for (int k = 0; k < 3; k++)
                for (int c = 0; c < NCH; c++) begin
                    t = tot[k][c] + (stats_en ? inc_of(k, c) : 0);
                    if (iv_tick) begin
                        if (k == 2) ecnt[k][c] = t % (max_of(k) + 1);
                        else        ecnt[k][c] = (t > max_of(k)) ? max_of(k) : t;
                        eovf[k][c] = (t > max_of(k));
                        tot[k][c]  = 0;
                    end else if (sw_clr) begin
                        tot[k][c] = 0;
                    end else begin
                        tot[k][c] = t;
                    end
                end
            evld = iv_tick;
            if (iv_tick) eseq = (eseq + 1) % 256;
        end
    endtask

    task automatic compare_all();
        logic [159:0] ea;
        logic [39:0]  eb, ec;
        logic [4:0]   oa, ob, oc;
        ea = '0; eb = '0; ec = '0;
        for (int c = 0; c < NCH; c++) begin
            ea[c*32 +: 32] = ecnt[0][c][31:0];
            eb[c*8 +: 8]   = ecnt[1][c][7:0];
            ec[c*8 +: 8]   = ecnt[2][c][7:0];
            oa[c] = eovf[0][c];
            ob[c] = eovf[1][c];
            oc[c] = eovf[2][c];
        end
        check("a_cnt", a_cnt, ea);
        check("b_cnt", 160'(b_cnt), 160'(eb));
        check("c_cnt", 160'(c_cnt), 160'(ec));
        check("a_ovf", 160'(a_ovf), 160'(oa));
        check("b_ovf", 160'(b_ovf), 160'(ob));
        check("c_ovf", 160'(c_ovf), 160'(oc));
        check("a_vld", 160'(a_vld), 160'(evld));
        check("b_vld", 160'(b_vld), 160'(evld));
        check("c_vld", 160'(c_vld), 160'(evld));
        check("a_seq", 160'(a_seq), 160'(eseq[7:0]));
        check("b_seq", 160'(b_seq), 160'(eseq[7:0]));
        check("c_seq", 160'(c_seq), 160'(eseq[7:0]));
    endtask

    // One clock: inputs are already set; model and DUT see the same edge,
    // then outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        stats_en = 1'b1; iv_tick = 1'b0; sw_clr = 1'b0;
        inc_a = '0; inc_b = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // Reset for 3 cycles, then 20 idle cycles.
        repeat (3) step();
        rst_n = 1'b1;
        repeat (20) step();

        // Basic count: ch2 counts 100 cycles, tick on the 100th.
        for (int i = 0; i < 100; i++) begin
            inc_a = 5'b00100;
            inc_b = 20'h00100;
            iv_tick = (i == 99);
            step();
        end
        check("basic_ch2_100", 160'(a_cnt[2*32 +: 32]), 160'd100);
        check("basic_seq_1", 160'(a_seq), 160'd1);
        idle_inputs();
        repeat (9) step();
        iv_tick = 1'b1;
        step();
        check("basic_ch2_0", 160'(a_cnt[2*32 +: 32]), 160'd0);
        check("basic_seq_2", 160'(a_seq), 160'd2);
        idle_inputs();

        // Saturate vs wrap: ch0 gets 15 per cycle for 20 cycles (300 total).
        for (int i = 0; i < 20; i++) begin
            inc_b = 20'h0000F;
            iv_tick = (i == 19);
            step();
        end
        check("sat_ch0_255", 160'(b_cnt[7:0]), 160'd255);
        check("sat_ovf0", 160'(b_ovf[0]), 160'd1);
        check("wrap_ch0_44", 160'(c_cnt[7:0]), 160'd44);
        check("wrap_ovf0", 160'(c_ovf[0]), 160'd1);
        idle_inputs();
        repeat (5) step();
        iv_tick = 1'b1;
        step();
        check("ovf_clears_b", 160'(b_ovf[0]), 160'd0);
        check("ovf_clears_c", 160'(c_ovf[0]), 160'd0);
        idle_inputs();

        // Simultaneous tick + sw_clr: ch1 holds 7, then +1 with both strobes.
        inc_a = 5'b00010; inc_b = 20'h00010;
        repeat (7) step();
        iv_tick = 1'b1; sw_clr = 1'b1;
        step();
        check("simul_ch1_8", 160'(a_cnt[1*32 +: 32]), 160'd8);
        idle_inputs();
        iv_tick = 1'b1;
        step();
        check("simul_ch1_0", 160'(a_cnt[1*32 +: 32]), 160'd0);
        idle_inputs();

        // sw_clr alone discards its cycle's increment; then 5 increments.
        for (int rep = 0; rep < 2; rep++) begin
            inc_a = 5'b01000; inc_b = 20'h01000;
            repeat (50) step();
            sw_clr = 1'b1;
            step();
            sw_clr = 1'b0;
            stats_en = (rep == 0);
            repeat (5) step();
            stats_en = 1'b1; inc_a = '0; inc_b = '0; iv_tick = 1'b1;
            step();
            check("swclr_ch3", 160'(a_cnt[3*32 +: 32]), (rep == 0) ? 160'd5 : 160'd0);
            idle_inputs();
        end

        // Mid-interval reset drops counts, then 256 back-to-back ticks.
        inc_a = 5'b10000; inc_b = 20'h10000;
        repeat (10) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        iv_tick = 1'b1;
        for (int i = 0; i < 256; i++) begin
            step();
            check("b2b_ch4_1", 160'(a_cnt[4*32 +: 32]), 160'd1);
            check("b2b_vld", 160'(a_vld), 160'd1);
        end
        check("seq_wrap_0", 160'(a_seq), 160'd0);
        idle_inputs();

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            inc_a    = 5'($urandom);
            inc_b    = 20'($urandom);
            stats_en = ($urandom_range(0, 9) != 0);
            iv_tick  = ($urandom_range(0, 39) == 0);
            sw_clr   = ($urandom_range(0, 59) == 0);
            rst_n    = ($urandom_range(0, 799) != 0);
            step();
        end
        rst_n = 1'b1;
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fc1_intstat_ctr.md
Name: fc1_intstat_ctr

Overview:
Parametrised interval-statistics engine for the FC1 layer. It accumulates NUM_CH independent per-lane event streams into saturating or wrapping counters (encoder full/empty, corrected/uncorrected FEC events, PCS loss-of-sync and future additions). On each interval tick it snapshots all counters into a stable output bank for register readout and restarts accumulation. It generalises the fixed five-counter 32-bit interval-stat record to any channel count, counter width and increment width, and adds per-channel overflow flags and a snapshot sequence number.

Parameters:
NUM_CH, 5, number of event channels; channel index 0..NUM_CH-1
CNT_W, 32, accumulator and snapshot width per channel (8..48)
INC_W, 1, per-channel increment width per cycle; value 0..2^INC_W-1 added each cycle
SAT, 1, 1 = saturate at all-ones; 0 = wrap modulo 2^CNT_W

Ports:
clk  in  1  single clock domain
rst_n  in  1  synchronous active-low reset
stats_en  in  1  1 = accumulate increments; 0 = ignore increments (ticks still honoured)
inc  in  NUM_CH*INC_W  per-channel increment; channel c at bits [c*INC_W +: INC_W]
iv_tick  in  1  single-cycle interval boundary strobe
sw_clr  in  1  single-cycle clear of running accumulators and overflow flags
snap_cnt  out  NUM_CH*CNT_W  snapshot bank; channel c at bits [c*CNT_W +: CNT_W]
snap_ovf  out  NUM_CH  per-channel flag: counter saturated or wrapped during the snapshotted interval
snap_vld  out  1  one-cycle pulse when the snapshot bank updates
snap_seq  out  8  snapshot sequence number; increments per snapshot, wraps 255 -> 0

Behaviour:
- Reset (rst_n low at a clk edge): accumulators, running overflow flags, snap_cnt, snap_ovf, snap_seq all 0; snap_vld 0. No events counted during reset cycles.
- Per cycle, per channel: sum = acc + (stats_en ? inc_c : 0), computed at CNT_W+1 bits.
  - Carry set and SAT=1: next = all-ones; running ovf_c set.
  - Carry set and SAT=0: next = sum[CNT_W-1:0]; running ovf_c set.
  - Accumulator already all-ones with SAT=1 and inc_c>0: stays all-ones; ovf_c set.
  - inc_c = 0 never sets ovf_c.
- iv_tick cycle: snapshot captures `next` (this cycle's increment belongs to the closing interval) and `ovf_c | this-cycle overflow`. Accumulators and running ovf then restart at 0. The first cycle after the tick counts toward the new interval.
- Latency: snap_cnt, snap_ovf, snap_seq update on the clk edge ending the iv_tick cycle. snap_vld is high for exactly that following cycle. Snapshot outputs hold until the next tick.
- snap_seq increments by 1 with each snapshot; 255 -> 0 wraps silently.
- sw_clr (no tick): accumulators and running ovf go to 0; the increment in that cycle is discarded; snapshot bank unaffected.
- sw_clr and iv_tick in the same cycle: the snapshot takes the tick-cycle value including that cycle's increment; accumulators restart at 0 (same result as a tick alone).
- Back-to-back ticks on consecutive cycles: the second snapshot holds only the single cycle's increment; snap_vld is high for 2 cycles and snap_seq advances by 2.
- stats_en low: accumulators hold, ticks still snapshot and clear.
- Reset asserted mid-interval: accumulated counts are lost, no snapshot is emitted, snap_seq returns to 0.
- Combinational paths: none from inputs to outputs; all outputs are registered.

Test Plan:
- Reset/idle: hold rst_n low 3 cycles, then 20 cycles with no inc and no tick -> all outputs 0, snap_vld never 1.
- Basic count: NUM_CH=5, INC_W=1; ch2 inc=1 for 100 cycles, tick on the 100th -> next cycle snap_cnt[ch2]=100, all other channels 0, snap_vld=1 for 1 cycle, snap_seq=1. Second tick 10 cycles later -> ch2=0, snap_seq=2.
- Saturate vs wrap: CNT_W=8, INC_W=4; ch0 inc=15 for 20 cycles (total 300), then tick. SAT=1 -> snap_cnt[ch0]=255, snap_ovf[0]=1. SAT=0 -> snap_cnt[ch0]=44, snap_ovf[0]=1. Next interval with no events -> snap_ovf[0]=0.
- Simultaneous events: ch1 accumulates 7, then one cycle with inc=1, iv_tick=1 and sw_clr=1 -> snap_cnt[ch1]=8; a following tick with no events gives 0.
- sw_clr alone and stats_en: ch3 accumulates 50, sw_clr with inc=1 in the same cycle, then 5 increments, then tick -> snap_cnt[ch3]=5. Repeat with stats_en=0 during 5 increments -> snap_cnt[ch3]=0.
- Back-to-back ticks and sequence wrap: issue 256 ticks with ch4 inc=1 every cycle and ticks on consecutive cycles -> every snapshot ch4=1, snap_vld continuously high, snap_seq wraps to 0 after the 256th tick.
